mem_access_ctrl: RTL and testbench

Sequences the single unified memory port of the multi-cycle RV32I core and shares it between instruction fetch and data load/store requesters. It arbitrates the two requesters and drives word-aligned memory cycles with byte enables and wait-state handling. It aligns and extends read data for LB/LH/LW/LBU/LHU, and pulses the load enable of the memory data register.

---
 rtl/mem_access_ctrl_if.sv | 43 ++++
 rtl/mem_access_ctrl.sv | 166 ++++++++++++++++
 tb/tb_mem_access_ctrl.sv | 220 ++++++++++++++++++++++
 3 files changed

// File: rtl/mem_access_ctrl_if.sv
// Bundle of the fetch, data and memory-port signals around mem_access_ctrl.
// The controller is the slave; the core requesters and the memory form the master side.
interface mem_access_ctrl_if;
   // Instruction fetch requester
   logic        if_req;
   logic [31:0] if_addr;
   logic [31:0] if_rdata;
   logic        if_done;
   logic        if_err;
   // Data load/store requester
   logic        d_req;
   logic        d_we;
   logic [31:0] d_addr;
   logic [31:0] d_wdata;
   logic [1:0]  d_size;
   logic        d_unsigned;
   logic [31:0] d_rdata;
   logic        d_done;
   logic        d_err;
   logic        mdr_load;
   // Unified memory port
   logic        mem_req;
   logic        mem_we;
   logic [31:0] mem_addr;
   logic [31:0] mem_wdata;
   logic [3:0]  mem_be;
   logic [31:0] mem_rdata;
   logic        mem_ready;

   modport slave (
      input  if_req, if_addr, d_req, d_we, d_addr, d_wdata, d_size, d_unsigned,
             mem_rdata, mem_ready,
      output if_rdata, if_done, if_err, d_rdata, d_done, d_err, mdr_load,
             mem_req, mem_we, mem_addr, mem_wdata, mem_be
   );

   modport master (
      output if_req, if_addr, d_req, d_we, d_addr, d_wdata, d_size, d_unsigned,
             mem_rdata, mem_ready,
      input  if_rdata, if_done, if_err, d_rdata, d_done, d_err, mdr_load,
             mem_req, mem_we, mem_addr, mem_wdata, mem_be
   );
endinterface

// File: rtl/mem_access_ctrl.sv
// Memory access controller: shares one word-wide memory port between instruction
// fetch and data load/store, with byte-lane formatting, wait states and a timeout.
module mem_access_ctrl #(
   parameter int unsigned TIMEOUT_CYCLES = 16
) (
   input logic               clk,
   input logic               rst,
   mem_access_ctrl_if.slave  bus
);

   localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES + 1);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

   typedef enum logic [1:0] {StIdle, StAccess, StResp} state_e;

   state_e           state_q;
   logic             owner_data_q;  // 1: data requester owns the access
   logic             we_q;
   logic [1:0]       lo_q;          // byte offset within the word
   logic [1:0]       size_q;
   logic             uns_q;
   logic [CNT_W-1:0] cnt_q;

   logic        grant_data;
   logic        grant_any;
   logic        grant_bad;
   logic [31:0] grant_addr;
   logic [31:0] grant_wdata;
   logic [3:0]  grant_be;
   logic [31:0] shifted;
   logic [31:0] load_data;

   // Arbitration (data wins) and store lane formatting of the request seen in IDLE
   always_comb begin
      grant_data  = bus.d_req;
      grant_any   = bus.d_req | bus.if_req;
      grant_addr  = grant_data ? bus.d_addr : bus.if_addr;
      grant_wdata = 32'h0;
      grant_be    = 4'b1111;
      grant_bad   = 1'b0;
      if (grant_data) begin
         grant_wdata = bus.d_wdata;
         case (bus.d_size)
            2'b00: begin
               grant_wdata = {4{bus.d_wdata[7:0]}};
               if (bus.d_we) grant_be = 4'b0001 << bus.d_addr[1:0];
            end
            2'b01: begin
               grant_wdata = {2{bus.d_wdata[15:0]}};
               if (bus.d_we) grant_be = bus.d_addr[1] ? 4'b1100 : 4'b0011;
               grant_bad   = bus.d_addr[0];
            end
            2'b10:   grant_bad = |bus.d_addr[1:0];
            default: grant_bad = 1'b1;
         endcase
      end else begin
         grant_bad = |bus.if_addr[1:0];
      end
   end

   // Load alignment and sign/zero extension of the word arriving from memory
   always_comb begin
      shifted = bus.mem_rdata >> {lo_q, 3'b000};
      case (size_q)
         2'b00:   load_data = uns_q ? {24'h0, shifted[7:0]} : {{24{shifted[7]}}, shifted[7:0]};
         2'b01:   load_data = uns_q ? {16'h0, shifted[15:0]} : {{16{shifted[15]}}, shifted[15:0]};
         default: load_data = bus.mem_rdata;
      endcase
   end

   // Access sequencer with registered memory-port and completion outputs
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q       <= StIdle;
         owner_data_q  <= 1'b0;
         we_q          <= 1'b0;
         lo_q          <= 2'b00;
         size_q        <= 2'b00;
         uns_q         <= 1'b0;
         cnt_q         <= '0;
         bus.mem_req   <= 1'b0;
         bus.mem_we    <= 1'b0;
         bus.mem_addr  <= 32'h0;
         bus.mem_wdata <= 32'h0;
         bus.mem_be    <= 4'b0000;
         bus.if_done   <= 1'b0;
         bus.if_err    <= 1'b0;
         bus.if_rdata  <= 32'h0;
         bus.d_done    <= 1'b0;
         bus.d_err     <= 1'b0;
         bus.d_rdata   <= 32'h0;
         bus.mdr_load  <= 1'b0;
      end else begin
         bus.if_done  <= 1'b0;
         bus.if_err   <= 1'b0;
         bus.d_done   <= 1'b0;
         bus.d_err    <= 1'b0;
         bus.mdr_load <= 1'b0;
         case (state_q)
            StIdle: begin
               if (grant_any) begin
                  owner_data_q  <= grant_data;
                  we_q          <= grant_data & bus.d_we;
                  lo_q          <= grant_addr[1:0];
                  size_q        <= grant_data ? bus.d_size : 2'b10;
                  uns_q         <= grant_data & bus.d_unsigned;
                  cnt_q         <= '0;
                  bus.mem_addr  <= {grant_addr[31:2], 2'b00};
                  bus.mem_wdata <= grant_wdata;
                  bus.mem_be    <= grant_be;
                  if (grant_bad) begin
                     // Rejected without a memory cycle
                     state_q <= StResp;
                     if (grant_data) begin
                        bus.d_done  <= 1'b1;
                        bus.d_err   <= 1'b1;
                        bus.d_rdata <= 32'h0;
                     end else begin
                        bus.if_done  <= 1'b1;
                        bus.if_err   <= 1'b1;
                        bus.if_rdata <= 32'h0;
                     end
                  end else begin
                     state_q     <= StAccess;
                     bus.mem_req <= 1'b1;
                     bus.mem_we  <= grant_data & bus.d_we;
                  end
               end
            end
            StAccess: begin
               if (bus.mem_ready) begin
                  state_q     <= StResp;
                  bus.mem_req <= 1'b0;
                  bus.mem_we  <= 1'b0;
                  if (owner_data_q) begin
                     bus.d_done   <= 1'b1;
                     bus.d_rdata  <= load_data;
                     bus.mdr_load <= ~we_q;
                  end else begin
                     bus.if_done  <= 1'b1;
                     bus.if_rdata <= bus.mem_rdata;
                  end
               end else if (cnt_q == CNT_LAST) begin
                  state_q     <= StResp;
                  bus.mem_req <= 1'b0;
                  bus.mem_we  <= 1'b0;
                  if (owner_data_q) begin
                     bus.d_done  <= 1'b1;
                     bus.d_err   <= 1'b1;
                     bus.d_rdata <= 32'h0;
                  end else begin
                     bus.if_done  <= 1'b1;
                     bus.if_err   <= 1'b1;
                     bus.if_rdata <= 32'h0;
                  end
               end else begin
                  cnt_q <= cnt_q + 1'b1;
               end
            end
            StResp:  state_q <= StIdle;
            default: state_q <= StIdle;
         endcase
      end
   end

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Self-checking bench for mem_access_ctrl: directed cases plus randomized transactions
// compared against an arithmetic reference model of the access rules.
module tb_mem_access_ctrl;

   localparam int unsigned TO = 16;

   logic clk = 1'b0;
   logic rst = 1'b0;
   int   checks = 0;
   int   errors = 0;

   always #5 clk = ~clk;

   mem_access_ctrl_if bus ();

   mem_access_ctrl #(.TIMEOUT_CYCLES(TO)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // Reference: is the request rejected without a memory cycle
   function automatic bit model_bad(input bit is_data, input logic [31:0] addr,
                                    input logic [1:0] size);
      if (!is_data) return (addr % 4) != 0;
      if (size == 3) return 1'b1;
      if (size == 1) return (addr % 2) != 0;
      if (size == 2) return (addr % 4) != 0;
      return 1'b0;
   endfunction

   function automatic logic [31:0] model_load(input logic [31:0] w, input logic [31:0] addr,
                                              input logic [1:0] size, input bit uns);
      logic [31:0] v;
      if (size == 0) begin
         v = (w >> (8 * (addr % 4))) & 32'hFF;
         if (!uns && v >= 128) v = v + 32'hFFFF_FF00;
      end else if (size == 1) begin
         v = (w >> (8 * (addr % 4))) & 32'hFFFF;
         if (!uns && v >= 32768) v = v + 32'hFFFF_0000;
      end else begin
         v = w;
      end
      return v;
   endfunction

   // One complete transaction starting at a negedge in IDLE; ends at a negedge in IDLE.
   task automatic txn(input bit is_data, input bit we, input logic [31:0] addr,
                      input logic [31:0] wdata, input logic [1:0] size, input bit uns,
                      input int waits, input logic [31:0] mrdata);
      bit          bad;
      bit          tmo;
      bit          store;
      logic [3:0]  ebe;
      logic [31:0] ewd;
      logic [31:0] erd;
      bad   = model_bad(is_data, addr, size);
      tmo   = (waits >= int'(TO));
      store = is_data && we;
      ebe   = 4'b1111;
      ewd   = wdata;
      if (store && size == 0) begin
         ebe = 4'(1 << (addr % 4));
         ewd = (wdata & 32'hFF) * 32'h0101_0101;
      end else if (store && size == 1) begin
         ebe = ((addr % 4) >= 2) ? 4'b1100 : 4'b0011;
         ewd = (wdata & 32'hFFFF) * 32'h0001_0001;
      end
      if (tmo) erd = 32'h0;
      else if (is_data) erd = model_load(mrdata, addr, size, uns);
      else erd = mrdata;

      if (is_data) begin
         bus.d_req = 1'b1; bus.d_we = we; bus.d_addr = addr; bus.d_wdata = wdata;
         bus.d_size = size; bus.d_unsigned = uns;
      end else begin
         bus.if_req = 1'b1; bus.if_addr = addr;
      end
      bus.mem_ready = 1'b0;
      @(negedge clk);
      bus.d_req  = 1'b0;
      bus.if_req = 1'b0;
      if (bad) begin
         check("bad_mem_req", {31'h0, bus.mem_req}, 32'h0);
         check("bad_done", {31'h0, is_data ? bus.d_done : bus.if_done}, 32'h1);
         check("bad_err", {31'h0, is_data ? bus.d_err : bus.if_err}, 32'h1);
         check("bad_mdr_load", {31'h0, bus.mdr_load}, 32'h0);
      end else begin
         check("mem_req", {31'h0, bus.mem_req}, 32'h1);
         check("mem_addr", bus.mem_addr, addr & 32'hFFFF_FFFC);
         check("mem_be", {28'h0, bus.mem_be}, {28'h0, ebe});
         check("mem_we", {31'h0, bus.mem_we}, {31'h0, store});
         if (store) check("mem_wdata", bus.mem_wdata, ewd);
         if (!tmo) begin
            repeat (waits) @(negedge clk);
            check("wait_mem_req", {31'h0, bus.mem_req}, 32'h1);
            bus.mem_ready = 1'b1;
            bus.mem_rdata = mrdata;
            @(negedge clk);
            bus.mem_ready = 1'b0;
         end else begin
            repeat (TO - 1) @(negedge clk);
            check("tmo_last_mem_req", {31'h0, bus.mem_req}, 32'h1);
            @(negedge clk);
         end
         check("done", {31'h0, is_data ? bus.d_done : bus.if_done}, 32'h1);
         check("other_done", {31'h0, is_data ? bus.if_done : bus.d_done}, 32'h0);
         check("err", {31'h0, is_data ? bus.d_err : bus.if_err}, {31'h0, tmo});
         check("resp_mem_req", {31'h0, bus.mem_req}, 32'h0);
         check("mdr_load", {31'h0, bus.mdr_load}, {31'h0, is_data && !we && !tmo});
         if (!store) check("rdata", is_data ? bus.d_rdata : bus.if_rdata, erd);
      end
      @(negedge clk);
      check("idle_done", {30'h0, bus.d_done, bus.if_done}, 32'h0);
   endtask

   initial begin
      int pulses;
      bus.if_req = 1'b0; bus.if_addr = 32'h0;
      bus.d_req = 1'b0; bus.d_we = 1'b0; bus.d_addr = 32'h0; bus.d_wdata = 32'h0;
      bus.d_size = 2'b00; bus.d_unsigned = 1'b0;
      bus.mem_rdata = 32'h0; bus.mem_ready = 1'b0;

      // Reset state
      #12;
      check("rst_mem_req", {31'h0, bus.mem_req}, 32'h0);
      check("rst_mem_we", {31'h0, bus.mem_we}, 32'h0);
      check("rst_mem_addr", bus.mem_addr, 32'h0);
      check("rst_mem_wdata", bus.mem_wdata, 32'h0);
      check("rst_mem_be", {28'h0, bus.mem_be}, 32'h0);
      check("rst_dones", {30'h0, bus.d_done, bus.if_done}, 32'h0);
      check("rst_errs", {30'h0, bus.d_err, bus.if_err}, 32'h0);
      check("rst_if_rdata", bus.if_rdata, 32'h0);
      check("rst_d_rdata", bus.d_rdata, 32'h0);
      check("rst_mdr_load", {31'h0, bus.mdr_load}, 32'h0);
      @(negedge clk);
      rst = 1'b1;

      // Fetch, loads, stores, rejects and a timeout
      txn(1'b0, 1'b0, 32'h100, 32'h0, 2'b10, 1'b0, 0, 32'h0050_0093);
      check("fetch_value", bus.if_rdata, 32'h0050_0093);
      txn(1'b1, 1'b0, 32'h203, 32'h0, 2'b00, 1'b0, 0, 32'h80FF_1234);
      check("lb_value", bus.d_rdata, 32'hFFFF_FF80);
      txn(1'b1, 1'b0, 32'h203, 32'h0, 2'b00, 1'b1, 1, 32'h80FF_1234);
      check("lbu_value", bus.d_rdata, 32'h0000_0080);
      txn(1'b1, 1'b0, 32'h202, 32'h0, 2'b01, 1'b0, 2, 32'h80FF_1234);
      check("lh_value", bus.d_rdata, 32'hFFFF_80FF);
      txn(1'b1, 1'b1, 32'h301, 32'h0000_00AB, 2'b00, 1'b0, 0, 32'h0);
      txn(1'b1, 1'b1, 32'h302, 32'h0000_BEEF, 2'b01, 1'b0, 1, 32'h0);
      txn(1'b1, 1'b0, 32'h201, 32'h0, 2'b10, 1'b0, 0, 32'h0);
      txn(1'b1, 1'b0, 32'h200, 32'h0, 2'b11, 1'b0, 0, 32'h0);
      txn(1'b0, 1'b0, 32'h102, 32'h0, 2'b10, 1'b0, 0, 32'h0);
      txn(1'b1, 1'b0, 32'h500, 32'h0, 2'b10, 1'b0, int'(TO), 32'h0);

      // Simultaneous requests: data first, fetch after returning to IDLE
      bus.if_req = 1'b1; bus.if_addr = 32'h104;
      bus.d_req = 1'b1; bus.d_we = 1'b0; bus.d_addr = 32'h200; bus.d_size = 2'b10;
      bus.d_unsigned = 1'b0;
      @(negedge clk);
      check("arb_data_addr", bus.mem_addr, 32'h200);
      bus.d_req = 1'b0;
      bus.mem_ready = 1'b1; bus.mem_rdata = 32'h1234_5678;
      @(negedge clk);
      check("arb_d_done", {31'h0, bus.d_done}, 32'h1);
      check("arb_if_done", {31'h0, bus.if_done}, 32'h0);
      check("arb_mdr_load", {31'h0, bus.mdr_load}, 32'h1);
      check("arb_d_rdata", bus.d_rdata, 32'h1234_5678);
      bus.mem_ready = 1'b0; bus.mem_rdata = 32'h0000_0013;
      @(negedge clk);
      check("arb_idle_mem_req", {31'h0, bus.mem_req}, 32'h0);
      @(negedge clk);
      check("arb_fetch_req", {31'h0, bus.mem_req}, 32'h1);
      check("arb_fetch_addr", bus.mem_addr, 32'h104);
      bus.if_req = 1'b0; bus.mem_ready = 1'b1;
      @(negedge clk);
      check("arb_fetch_done", {31'h0, bus.if_done}, 32'h1);
      check("arb_fetch_rdata", bus.if_rdata, 32'h0000_0013);
      check("arb_fetch_d_done", {31'h0, bus.d_done}, 32'h0);
      bus.mem_ready = 1'b0;
      @(negedge clk);

      // Reset in the middle of an access
      bus.d_req = 1'b1; bus.d_we = 1'b0; bus.d_addr = 32'h400; bus.d_size = 2'b10;
      @(negedge clk);
      bus.d_req = 1'b0;
      check("mid_rst_pre_req", {31'h0, bus.mem_req}, 32'h1);
      #2 rst = 1'b0;
      #1;
      check("mid_rst_mem_req", {31'h0, bus.mem_req}, 32'h0);
      @(negedge clk);
      rst = 1'b1;
      bus.mem_ready = 1'b1;
      pulses = 0;
      repeat (4) begin
         @(negedge clk);
         if (bus.d_done || bus.if_done || bus.mem_req) pulses++;
      end
      check("mid_rst_no_activity", 32'(pulses), 32'h0);
      bus.mem_ready = 1'b0;

      // Randomized transactions
      for (int i = 0; i < 40; i++) begin
         txn(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), $urandom, $urandom,
             2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
             int'($urandom_range(0, 3)), $urandom);
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
